pong_score_keeper: RTL and testbench
====================================

Name: pong_score_keeper

Overview:
- Score and match-control stage between the game state machine and the seven-segment score displays.
- Takes point events from the game logic and keeps a two-digit BCD score for each player.
- Runs the serve-delay and game-over sequencing, and tells the game logic when a new serve may start.
- Its BCD digit outputs drive the hex display decoders directly; its serve/freeze outputs gate ball motion.

Parameters:
- WIN_SCORE, 11, points needed to win a match (range 1..99).
- SERVE_DELAY, 100, number of tick pulses the ball stays frozen after a point (1 s at 100 Hz).
- OVER_HOLD, 300, number of tick pulses the game-over state lasts before auto-restart; 0 means hold until reset.

Ports:
- CLOCK_50  in  1  system clock; all logic runs on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable pulse at 100 Hz, already synchronous to CLOCK_50.
- pause  in  1  level; when high, freezes all counters and timers.
- point_1  in  1  level from game logic: ball has passed paddle 2, so player 1 scores.
- point_2  in  1  level from game logic: ball has passed paddle 1, so player 2 scores.
- score_1_ones, score_1_tens  out  4 each  BCD digits for player 1.
- score_2_ones, score_2_tens  out  4 each  BCD digits for player 2.
- freeze  out  1  high means the ball must not move.
- serve_go  out  1  one-cycle pulse: re-centre the ball and serve.
- serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2 (toward the player who just lost the point).
- game_over  out  1  high while in the OVER state.
- winner  out  2  00 = none, 01 = player 1, 10 = player 2.

Behaviour:
- Reset (async assert, sync release): all digits 0, freeze=1, serve_go=0, serve_dir=0, game_over=0, winner=00. FSM enters SERVE with timer=0.
- Point detection:
  - point_1 and point_2 are rising-edge detected on CLOCK_50. A level held high counts once.
  - Edges are accepted only in state PLAY with pause=0. Edges in any other state are discarded.
- FSM states: SERVE, PLAY, SCORED, OVER.
- SERVE:
  - freeze=1; timer increments on tick when pause=0.
  - When timer reaches SERVE_DELAY: serve_go=1 for exactly one cycle, timer cleared, go to PLAY on the next cycle.
- PLAY:
  - freeze=0.
  - On an accepted point edge: increment the scorer's BCD count, set serve_dir toward the loser, go to SCORED. Increment latency is 1 cycle after the edge is sampled.
  - Simultaneous point_1 and point_2 edges in one cycle: neither scores; go to SERVE with serve_dir unchanged.
- SCORED (one cycle):
  - freeze=1.
  - If the updated score ≥ WIN_SCORE: winner set, game_over=1, go to OVER.
  - Otherwise go to SERVE with timer=0.
- OVER:
  - freeze=1; scores held.
  - If OVER_HOLD>0: after OVER_HOLD ticks, clear scores, winner and game_over, then go to SERVE.
  - If OVER_HOLD=0: stay in OVER until reset_n.
- BCD arithmetic:
  - Ones digit wraps 9→0 and carries into tens.
  - At 99 the score saturates; no wrap to 00.
  - Digits never hold values above 9.
- pause=1:
  - tick is ignored and point edges are dropped.
  - State, scores and outputs hold, except that a serve_go already being driven still completes.
  - Deasserting pause resumes the timer from its held value.
- reset_n asserted mid-match clears everything immediately, regardless of state.

Optional Feature:
- Macro: PONG_WIN_BY_TWO_EN.
- Defined: a win in SCORED additionally requires the scorer to lead by at least 2. At scores ≥ WIN_SCORE without a 2-point lead, the FSM continues to SERVE (deuce). The 99 saturation still applies; reaching 99 with a 1-point lead also wins.
- Undefined: the first player to reach WIN_SCORE wins regardless of margin.

Test Plan:
- Serve after reset: release reset_n, apply 100 tick pulses -> serve_go pulses once on the cycle the 100th tick is counted; freeze falls on the next cycle; state PLAY.
- Single point: in PLAY, hold point_1 high for 50 cycles -> score_1 goes 00→01 exactly once; serve_dir=1; freeze=1; next serve_go after 100 ticks.
- BCD carry and saturation: with WIN_SCORE=99, drive 10 player-2 points -> score_2_tens=1, score_2_ones=0. Drive to 99 plus one extra point -> stays at 99 and winner=10.
- Match end: with WIN_SCORE=11 and OVER_HOLD=300, player 1 reaches 11-3 -> game_over=1, winner=01. After 300 ticks -> all digits 0, winner=00, state SERVE.
- Simultaneous and pause: point_1 and point_2 rise in the same cycle -> no score change, state SERVE. With pause=1 during SERVE, 200 ticks -> no serve_go; after pause=0, the remaining ticks complete the delay.
- With PONG_WIN_BY_TWO_EN, at 10-10: scores reaching 11-10 do not end the match; 12-10 -> game_over=1, winner=01. Reset mid-OVER -> immediate clear.

Source files
------------

// File: rtl/pong_score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_score_keeper                                             |
// | Purpose  : BCD score keeping plus serve-delay / game-over sequencing.    |
// |            Optional macro PONG_WIN_BY_TWO_EN requires a 2-point lead.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pong_score_keeper #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 100,
  parameter int OVER_HOLD   = 300
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       pause,
  input  logic       point_1,
  input  logic       point_2,
  output logic [3:0] score_1_ones,
  output logic [3:0] score_1_tens,
  output logic [3:0] score_2_ones,
  output logic [3:0] score_2_tens,
  output logic       freeze,
  output logic       serve_go,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int c_TMAX = (SERVE_DELAY > OVER_HOLD) ? SERVE_DELAY : OVER_HOLD;
  localparam int c_TW   = $clog2(c_TMAX + 1);
  localparam logic [c_TW-1:0] c_SERVE_LAST = c_TW'(SERVE_DELAY - 1);
  localparam logic [c_TW-1:0] c_OVER_LAST  = c_TW'((OVER_HOLD > 0) ? OVER_HOLD - 1 : 0);
  localparam logic [6:0]      c_WIN        = 7'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_SERVE  = 2'd0,
    S_PLAY   = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_TW-1:0] r_timer;
  logic            r_pt1_d, r_pt2_d;
  logic [3:0]      r_s1_ones, r_s1_tens, r_s2_ones, r_s2_tens;
  logic            r_freeze, r_serve_go, r_serve_dir, r_game_over;
  logic [1:0]      r_winner;

  logic            w_edge_1, w_edge_2;
  logic [6:0]      w_val_1, w_val_2, w_scorer;
  logic            w_win;
`ifdef PONG_WIN_BY_TWO_EN
  logic [6:0]      w_other;
`endif

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)            r = v;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] bcd_val(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  always_comb begin
    w_edge_1 = point_1 & ~r_pt1_d;
    w_edge_2 = point_2 & ~r_pt2_d;
    w_val_1  = bcd_val(r_s1_tens, r_s1_ones);
    w_val_2  = bcd_val(r_s2_tens, r_s2_ones);
    // serve_dir was just pointed at the loser, so 1 means player 1 scored.
    w_scorer = r_serve_dir ? w_val_1 : w_val_2;
`ifdef PONG_WIN_BY_TWO_EN
    w_other  = r_serve_dir ? w_val_2 : w_val_1;
    w_win    = (w_scorer >= c_WIN) &&
               ((w_scorer >= w_other + 7'd2) || (w_scorer == 7'd99));
`else
    w_win    = (w_scorer >= c_WIN);
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_SERVE;
      r_timer     <= '0;
      r_pt1_d     <= 1'b0;
      r_pt2_d     <= 1'b0;
      r_s1_ones   <= 4'd0;
      r_s1_tens   <= 4'd0;
      r_s2_ones   <= 4'd0;
      r_s2_tens   <= 4'd0;
      r_freeze    <= 1'b1;
      r_serve_go  <= 1'b0;
      r_serve_dir <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 2'b00;
    end else begin
      r_pt1_d    <= point_1;
      r_pt2_d    <= point_2;
      // The serve pulse always ends after one cycle, even under pause.
      r_serve_go <= 1'b0;
      if (!pause) begin
        case (r_state)
          S_SERVE: begin
            if (tick) begin
              if (r_timer == c_SERVE_LAST) begin
                r_timer    <= '0;
                r_serve_go <= 1'b1;
                r_state    <= S_PLAY;
              end else begin
                r_timer <= r_timer + c_TW'(1);
              end
            end
          end
          S_PLAY: begin
            r_freeze <= 1'b0;
            if (w_edge_1 && w_edge_2) begin
              r_freeze <= 1'b1;
              r_timer  <= '0;
              r_state  <= S_SERVE;
            end else if (w_edge_1) begin
              {r_s1_tens, r_s1_ones} <= bcd_inc({r_s1_tens, r_s1_ones});
              r_serve_dir <= 1'b1;
              r_freeze    <= 1'b1;
              r_state     <= S_SCORED;
            end else if (w_edge_2) begin
              {r_s2_tens, r_s2_ones} <= bcd_inc({r_s2_tens, r_s2_ones});
              r_serve_dir <= 1'b0;
              r_freeze    <= 1'b1;
              r_state     <= S_SCORED;
            end
          end
          S_SCORED: begin
            r_timer <= '0;
            if (w_win) begin
              r_game_over <= 1'b1;
              r_winner    <= r_serve_dir ? 2'b01 : 2'b10;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_SERVE;
            end
          end
          S_OVER: begin
            // With OVER_HOLD of zero the match stays over until reset.
            if ((OVER_HOLD > 0) && tick) begin
              if (r_timer == c_OVER_LAST) begin
                r_timer     <= '0;
                r_s1_ones   <= 4'd0;
                r_s1_tens   <= 4'd0;
                r_s2_ones   <= 4'd0;
                r_s2_tens   <= 4'd0;
                r_game_over <= 1'b0;
                r_winner    <= 2'b00;
                r_state     <= S_SERVE;
              end else begin
                r_timer <= r_timer + c_TW'(1);
              end
            end
          end
          default: r_state <= S_SERVE;
        endcase
      end
    end
  end

  assign score_1_ones = r_s1_ones;
  assign score_1_tens = r_s1_tens;
  assign score_2_ones = r_s2_ones;
  assign score_2_tens = r_s2_tens;
  assign freeze       = r_freeze;
  assign serve_go     = r_serve_go;
  assign serve_dir    = r_serve_dir;
  assign game_over    = r_game_over;
  assign winner       = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_pong_score_keeper                                          |
// | Purpose  : Self-checking bench; two instances (match rules, saturation). |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pong_score_keeper;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] tk, ps, p1, p2;
  logic [1:0][3:0] s1o, s1t, s2o, s2t;
  logic [1:0] frz, sgo, sdir, gov;
  logic [1:0][1:0] win;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: integer scores per instance.
  int m1[2], m2[2], mdir[2], mover[2], mwin[2];

  always #5 clk = ~clk;

  pong_score_keeper #(.WIN_SCORE(11), .SERVE_DELAY(100), .OVER_HOLD(300)) u_dut0 (
    .CLOCK_50(clk), .reset_n(rst_n), .tick(tk[0]), .pause(ps[0]),
    .point_1(p1[0]), .point_2(p2[0]),
    .score_1_ones(s1o[0]), .score_1_tens(s1t[0]),
    .score_2_ones(s2o[0]), .score_2_tens(s2t[0]),
    .freeze(frz[0]), .serve_go(sgo[0]), .serve_dir(sdir[0]),
    .game_over(gov[0]), .winner(win[0])
  );

  pong_score_keeper #(.WIN_SCORE(99), .SERVE_DELAY(3), .OVER_HOLD(0)) u_dut1 (
    .CLOCK_50(clk), .reset_n(rst_n), .tick(tk[1]), .pause(ps[1]),
    .point_1(p1[1]), .point_2(p2[1]),
    .score_1_ones(s1o[1]), .score_1_tens(s1t[1]),
    .score_2_ones(s2o[1]), .score_2_tens(s2t[1]),
    .freeze(frz[1]), .serve_go(sgo[1]), .serve_dir(sdir[1]),
    .game_over(gov[1]), .winner(win[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit model_win(input int mine, input int theirs, input int target);
`ifdef PONG_WIN_BY_TWO_EN
    return (mine >= target) && ((mine - theirs >= 2) || (mine == 99));
`else
    return mine >= target;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m1[i] = 0; m2[i] = 0; mdir[i] = 0; mover[i] = 0; mwin[i] = 0;
    end
  endtask

  task automatic chk_scores(input int d, input string tag);
    chk({tag, "_s1_tens"}, s1t[d], m1[d] / 10);
    chk({tag, "_s1_ones"}, s1o[d], m1[d] % 10);
    chk({tag, "_s2_tens"}, s2t[d], m2[d] / 10);
    chk({tag, "_s2_ones"}, s2o[d], m2[d] % 10);
  endtask

  task automatic chk_cleared(input int d, input string tag);
    chk_scores(d, tag);
    chk({tag, "_freeze"}, frz[d], 1);
    chk({tag, "_serve_go"}, sgo[d], 0);
    chk({tag, "_serve_dir"}, sdir[d], 0);
    chk({tag, "_game_over"}, gov[d], 0);
    chk({tag, "_winner"}, win[d], 0);
  endtask

  // Count ticks until the serve pulse; optionally pause 200 ticks midway.
  task automatic run_serve(input int d, input int delay, input bit with_pause);
    int n, stray;
    bit prev_tick, seen, paused, expect_go;
    n = 0; stray = 0; prev_tick = 0; seen = 0; paused = 0;
    for (int c = 0; c < 4 * delay + 300 && !seen; c++) begin
      @(negedge clk);
      expect_go = prev_tick && (n == delay);
      if (expect_go) begin
        chk("serve_go", sgo[d], 1);
        chk("serve_freeze_hold", frz[d], 1);
        chk("serve_dir", sdir[d], mdir[d]);
        seen = 1;
      end else if (sgo[d] !== 1'b0) begin
        stray++;
      end
      tk[d] = 1'b0;
      if (!seen) begin
        if (with_pause && !paused && n == delay / 2) begin
          ps[d] = 1'b1;
          tk[d] = 1'b1;
          repeat (200) begin
            @(negedge clk);
            if (sgo[d] !== 1'b0) stray++;
          end
          tk[d] = 1'b0;
          ps[d] = 1'b0;
          paused = 1;
          prev_tick = 0;
        end else begin
          tk[d] = (n < delay) && ($urandom_range(0, 2) != 0);
          if (tk[d]) n++;
          prev_tick = tk[d];
        end
      end
    end
    tk[d] = 1'b0;
    chk("serve_seen", seen, 1);
    chk("serve_stray", stray, 0);
    @(negedge clk);
    chk("serve_pulse_width", sgo[d], 0);
    chk("freeze_release", frz[d], 0);
  endtask

  task automatic score_point(input int d, input int who, input int hold);
    bit won;
    int target;
    target = (d == 0) ? 11 : 99;
    if (who == 1) m1[d] = (m1[d] < 99) ? m1[d] + 1 : 99;
    else          m2[d] = (m2[d] < 99) ? m2[d] + 1 : 99;
    mdir[d] = (who == 1) ? 1 : 0;
    won = (who == 1) ? model_win(m1[d], m2[d], target) : model_win(m2[d], m1[d], target);
    @(negedge clk);
    if (who == 1) p1[d] = 1'b1; else p2[d] = 1'b1;
    @(negedge clk);
    chk_scores(d, "point");
    chk("point_freeze", frz[d], 1);
    chk("point_dir", sdir[d], mdir[d]);
    @(negedge clk);
    mover[d] = won ? 1 : 0;
    mwin[d]  = won ? who : 0;
    chk("point_over", gov[d], mover[d]);
    chk("point_winner", win[d], mwin[d]);
    repeat (hold) @(negedge clk);
    p1[d] = 1'b0;
    p2[d] = 1'b0;
    @(negedge clk);
    chk_scores(d, "point_held");
  endtask

  task automatic over_hold(input int d, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tk[d] = 1'b1;
      @(negedge clk);
      tk[d] = 1'b0;
      if (i == hold - 2) chk("over_before_end", gov[d], 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    m1[d] = 0; m2[d] = 0; mover[d] = 0; mwin[d] = 0;
    chk_scores(d, "over_end");
    chk("over_end_game_over", gov[d], 0);
    chk("over_end_winner", win[d], 0);
    chk("over_end_freeze", frz[d], 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, who;
    rst_n = 1'b0;
    tk = '0; ps = '0; p1 = '0; p2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_cleared(0, "reset0");
    chk_cleared(1, "reset1");
    rst_n = 1'b1;

    // First serve, with a 200-tick pause in the middle of the delay.
    run_serve(0, 100, 1'b1);

    // Edge arriving under pause is dropped, and the held level never scores.
    @(negedge clk);
    ps[0] = 1'b1; p1[0] = 1'b1;
    repeat (3) @(negedge clk);
    ps[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk_scores(0, "pause_drop");
    chk("pause_drop_freeze", frz[0], 0);
    p1[0] = 1'b0;

    score_point(0, 1, 50);
    run_serve(0, 100, 1'b0);

    // Simultaneous edges: no score, back to serve, direction kept.
    @(negedge clk);
    p1[0] = 1'b1; p2[0] = 1'b1;
    @(negedge clk);
    p1[0] = 1'b0; p2[0] = 1'b0;
    chk_scores(0, "simul");
    chk("simul_freeze", frz[0], 1);
    chk("simul_dir", sdir[0], mdir[0]);
    run_serve(0, 100, 1'b0);

    // Match 1: player 1 favoured, random hold lengths.
    guard = 0;
    while (!mover[0] && guard < 80) begin
      who = ($urandom_range(0, 3) != 0) ? 1 : 2;
      score_point(0, who, $urandom_range(1, 50));
      if (!mover[0]) run_serve(0, 100, 1'b0);
      guard++;
    end
    chk("match1_over", gov[0], 1);
    over_hold(0, 300);
    run_serve(0, 100, 1'b0);

    // Match 2: alternate to 10-10, then player 1 scores until the match ends.
    for (int k = 0; k < 10; k++) begin
      score_point(0, 1, $urandom_range(1, 20));
      run_serve(0, 100, 1'b0);
      score_point(0, 2, $urandom_range(1, 20));
      run_serve(0, 100, 1'b0);
    end
    guard = 0;
    while (!mover[0] && guard < 4) begin
      score_point(0, 1, $urandom_range(1, 20));
      if (!mover[0]) run_serve(0, 100, 1'b0);
      guard++;
    end
    chk("match2_over", gov[0], 1);
    chk("match2_winner", win[0], 1);

    // Saturation instance: player 2 scores all the way to 99.
    run_serve(1, 3, 1'b0);
    guard = 0;
    while (!mover[1] && guard < 120) begin
      score_point(1, 2, $urandom_range(1, 4));
      if (m2[1] == 10) begin
        chk("carry_tens", s2t[1], 1);
        chk("carry_ones", s2o[1], 0);
      end
      if (!mover[1]) run_serve(1, 3, 1'b0);
      guard++;
    end
    chk("sat_over", gov[1], 1);
    @(negedge clk);
    p2[1] = 1'b1;
    repeat (4) @(negedge clk);
    p2[1] = 1'b0;
    @(negedge clk);
    chk("sat_tens", s2t[1], 9);
    chk("sat_ones", s2o[1], 9);
    chk("sat_winner", win[1], 2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      tk[1] = ~tk[1];
    end
    tk[1] = 1'b0;
    @(negedge clk);
    chk("hold_forever_over", gov[1], 1);
    chk("hold_forever_winner", win[1], 2);

    // Asynchronous reset while both instances sit in game-over.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_cleared(0, "async_rst0");
    chk_cleared(1, "async_rst1");
    @(negedge clk);
    rst_n = 1'b1;
    run_serve(0, 100, 1'b0);
    run_serve(1, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
